// File: rtl/rst_seq22.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq22
// Description : Global reset hold followed by a timed, ordered release of 22
//               per-domain reset masks.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq22 #(
    parameter int HOLDCYC = 16
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        swrst,
    input  logic [21:0] swmsk,
    input  logic [7:0]  stepdly,
    output logic        orst_,
    output logic [21:0] rstmsk,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_ASSERT = 2'd0,
        S_STAGE  = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [15:0] c_hold_last = 16'(HOLDCYC - 1);
    localparam logic [4:0]  c_last_idx  = 5'd21;
    localparam logic [21:0] c_all_mask  = 22'h3FFFFF;

    state_t      r_state, w_state;
    logic [15:0] r_cnt,   w_cnt;
    logic [7:0]  r_step,  w_step;
    logic [7:0]  r_gap,   w_gap;
    logic [4:0]  r_idx,   w_idx;
    logic        w_orst;
    logic [21:0] w_rstmsk;
    logic        w_busy;
    logic        w_done;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_ASSERT;
            r_cnt   <= 16'd0;
            r_step  <= 8'd0;
            r_gap   <= 8'd0;
            r_idx   <= 5'd0;
            orst_   <= 1'b0;
            rstmsk  <= c_all_mask;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_step  <= w_step;
            r_gap   <= w_gap;
            r_idx   <= w_idx;
            orst_   <= w_orst;
            rstmsk  <= w_rstmsk;
            busy    <= w_busy;
            done    <= w_done;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_step   = r_step;
        w_gap    = r_gap;
        w_idx    = r_idx;
        w_orst   = orst_;
        w_rstmsk = rstmsk;
        w_busy   = busy;
        w_done   = done;

        if (swrst) begin
            // Software restart overrides everything, including already-released domains.
            w_state  = S_ASSERT;
            w_cnt    = 16'd0;
            w_step   = 8'd0;
            w_gap    = 8'd0;
            w_idx    = 5'd0;
            w_orst   = 1'b0;
            w_rstmsk = c_all_mask;
            w_busy   = 1'b1;
            w_done   = 1'b0;
        end else begin
            case (r_state)
                S_ASSERT: begin
                    if (r_cnt == c_hold_last) begin
                        w_orst  = 1'b1;
                        w_step  = stepdly;
                        w_idx   = 5'd0;
                        w_gap   = 8'd0;
                        w_cnt   = 16'd0;
                        w_state = S_STAGE;
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
                S_STAGE: begin
                    // Masked domains still consume a full slot so spacing is fixed.
                    if (r_gap == r_step) begin
                        w_rstmsk[r_idx] = swmsk[r_idx];
                        w_gap           = 8'd0;
                        if (r_idx == c_last_idx) begin
                            w_state = S_DONE;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end else begin
                            w_idx = r_idx + 5'd1;
                        end
                    end else begin
                        w_gap = r_gap + 8'd1;
                    end
                end
                S_DONE: begin
                    w_rstmsk = swmsk;
                end
                default: begin
                    w_state = S_ASSERT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_seq22.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq22
// Description : Scoreboard bench for rst_seq22 using directed edge checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq22;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        swrst = 1'b0;
    logic [21:0] swmsk = 22'h0;
    logic [7:0]  stepdly = 8'd0;
    logic        orst_;
    logic [21:0] rstmsk;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    typedef struct {
        int          at;
        string       nm;
        logic        o;
        logic [21:0] m;
        logic        b;
        logic        d;
    } exp_t;

    exp_t sb[$];

    rst_seq22 #(.HOLDCYC(16)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .swrst   (swrst),
        .swmsk   (swmsk),
        .stepdly (stepdly),
        .orst_   (orst_),
        .rstmsk  (rstmsk),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Edge number since the last rst_ release; edge 1 is the first rising edge.
    always @(posedge clk or negedge rst_) begin
        if (!rst_) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    // Monitor: pops every checkpoint whose edge has been reached.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= edge_n) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.at < edge_n) begin
                bad++;
                $display("FAIL %s: checkpoint for edge %0d missed (now edge %0d)", e.nm, e.at, edge_n);
            end else if (orst_ !== e.o || rstmsk !== e.m || busy !== e.b || done !== e.d) begin
                bad++;
                $display("FAIL %s @edge %0d: got orst_=%b rstmsk=%06h busy=%b done=%b, want orst_=%b rstmsk=%06h busy=%b done=%b",
                         e.nm, edge_n, orst_, rstmsk, busy, done, e.o, e.m, e.b, e.d);
            end
        end
    end

    task automatic expect_at(input int at, input string nm, input logic o,
                             input logic [21:0] m, input logic b, input logic d);
        exp_t e;
        e.at = at; e.nm = nm; e.o = o; e.m = m; e.b = b; e.d = d;
        sb.push_back(e);
    endtask

    task automatic to_edge(input int n);
        int guard = 0;
        while (edge_n < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic start_scn(input logic sr, input logic [7:0] sd, input logic [21:0] sm);
        rst_    = 1'b0;
        swrst   = sr;
        stepdly = sd;
        swmsk   = sm;
        expect_at(0, "reset_state", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_ = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checkpoints left unchecked, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [21:0] m;

        // Normal sequence, stepdly=3, with stepdly changed mid-STAGE, then async reset in DONE.
        start_scn(1'b0, 8'd3, 22'h0);
        expect_at(15, "hold_end", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(16, "orst_rise", 1'b1, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(19, "pre_rel0", 1'b1, 22'h3FFFFF, 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) begin
            m = 22'h3FFFFF << (i + 1);
            if (i == 21) expect_at(103, "pre_last", 1'b1, 22'h200000, 1'b1, 1'b0);
            expect_at(20 + 4 * i, $sformatf("rel%0d", i), 1'b1, m, (i != 21), (i == 21));
        end
        expect_at(110, "done_hold", 1'b1, 22'h0, 1'b0, 1'b1);
        to_edge(30);
        stepdly = 8'd9;
        to_edge(111);
        expect_at(0, "async_rst_done", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        rst_ = 1'b0;
        drain();

        // stepdly=0 with domains 0 and 2 held; then live mirroring in DONE.
        start_scn(1'b0, 8'd0, 22'h000005);
        expect_at(16, "s2_orst", 1'b1, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(17, "s2_dom0_held", 1'b1, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(18, "s2_dom1_rel", 1'b1, 22'h3FFFFD, 1'b1, 1'b0);
        expect_at(19, "s2_dom2_held", 1'b1, 22'h3FFFFD, 1'b1, 1'b0);
        expect_at(20, "s2_dom3_rel", 1'b1, 22'h3FFFF5, 1'b1, 1'b0);
        expect_at(37, "s2_pre_done", 1'b1, 22'h200005, 1'b1, 1'b0);
        expect_at(38, "s2_done", 1'b1, 22'h000005, 1'b0, 1'b1);
        expect_at(40, "s2_done_mirror", 1'b1, 22'h000005, 1'b0, 1'b1);
        expect_at(41, "s2_clr_bit2", 1'b1, 22'h000001, 1'b0, 1'b1);
        expect_at(42, "s2_steady", 1'b1, 22'h000001, 1'b0, 1'b1);
        expect_at(43, "s2_set_all", 1'b1, 22'h3FFFFF, 1'b0, 1'b1);
        to_edge(40);
        swmsk = 22'h000001;
        to_edge(42);
        swmsk = 22'h3FFFFF;
        drain();

        // One-cycle swrst at edge 50 mid-STAGE.
        start_scn(1'b0, 8'd3, 22'h0);
        expect_at(48, "s3_rel7", 1'b1, 22'h3FFF00, 1'b1, 1'b0);
        expect_at(49, "s3_pre_swrst", 1'b1, 22'h3FFF00, 1'b1, 1'b0);
        expect_at(50, "s3_swrst", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(51, "s3_hold1", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(65, "s3_hold15", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(66, "s3_orst_rise", 1'b1, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(70, "s3_rel0", 1'b1, 22'h3FFFFE, 1'b1, 1'b0);
        to_edge(49);
        swrst = 1'b1;
        to_edge(50);
        swrst = 1'b0;
        drain();

        // swrst held for the first 10 edges after rst_ release.
        start_scn(1'b1, 8'd0, 22'h0);
        expect_at(5, "s4_held5", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(10, "s4_held10", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(25, "s4_hold15", 1'b0, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(26, "s4_orst_rise", 1'b1, 22'h3FFFFF, 1'b1, 1'b0);
        expect_at(27, "s4_rel0", 1'b1, 22'h3FFFFE, 1'b1, 1'b0);
        to_edge(10);
        swrst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rst_seq22.md
RST_SEQ22 -- requirements
Module: rst_seq22

Interface
REQ-001 The block SHALL have parameter HOLDCYC, default 16, giving the number of cycles the global reset is held low; legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port swrst  input  1  synchronous software reset request, active high.
REQ-005 The block SHALL have port swmsk  input  22  per-domain hold; a 1 keeps that domain in reset.
REQ-006 The block SHALL have port stepdly  input  8  idle cycles between consecutive domain releases.
REQ-007 The block SHALL have port orst_  output  1  global active-low reset, fed to the per-clock reset synchronizer bank.
REQ-008 The block SHALL have port rstmsk  output  22  per-domain reset mask; a 1 holds domain i in reset, fed to the synchronizer bank.
REQ-009 The block SHALL have port busy  output  1  high while the sequence is in progress.
REQ-010 The block SHALL have port done  output  1  high once all domains have been processed.

Function
REQ-011 The block SHALL contain exactly three states: ASSERT, STAGE and DONE.
REQ-012 The block SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-013 In ASSERT, a 16-bit counter SHALL count from 0 on each edge; on the edge where the counter equals HOLDCYC-1, the block SHALL set orst_ to 1, latch stepdly into an 8-bit step register, clear the domain index and gap counter, and enter STAGE.
REQ-014 In STAGE, the gap counter SHALL increment on each edge until it equals the latched stepdly value. On that edge the block SHALL set rstmsk[idx] to swmsk[idx], clear the gap counter and increment idx.
REQ-015 Each domain release SHALL take exactly latched stepdly+1 cycles, whether or not swmsk[idx] is 1; masked domains stay at 1 but still consume their slot.
REQ-016 With stepdly=0, the block SHALL release one domain per cycle.
REQ-017 The block SHALL process domains strictly in ascending order, 0 to 21. The 5-bit idx SHALL never exceed 21.
REQ-018 On the edge that processes idx=21, the block SHALL enter DONE, set busy to 0 and set done to 1 on that same edge.
REQ-019 In DONE, on every edge rstmsk SHALL equal swmsk, so that each domain can be held or released individually with a 1-cycle latency.
REQ-020 The block SHALL ignore changes to stepdly after the ASSERT-to-STAGE edge until the next sequence.
REQ-021 swrst=1 on any edge, in any state, SHALL have priority over all other behaviour and SHALL set orst_=0, rstmsk=all ones, busy=1 and done=0, clear all counters and idx, and enter ASSERT.
REQ-022 While swrst is held high, the block SHALL restart every cycle and remain in ASSERT with its counter at 0.
REQ-023 The ASSERT hold count SHALL begin on the first edge on which swrst is 0.
REQ-024 A swrst arriving mid-STAGE SHALL re-mask every already-released domain on that same edge.

Reset
REQ-025 While rst_=0, the block SHALL hold, asynchronously: orst_=0, rstmsk=22'h3FFFFF, busy=1, done=0, state=ASSERT, and all counters and idx at 0.
REQ-026 After rst_ deasserts, the block SHALL start the sequence without any other stimulus.
REQ-027 With swrst=0, orst_ SHALL rise on the HOLDCYC-th rising clk edge after rst_ deasserts.
REQ-028 Assertion of rst_ at any point, including mid-STAGE or in DONE, SHALL return every output to its reset value immediately, without waiting for a clock edge.

Verification
REQ-029 The bench SHALL cover: HOLDCYC=16, stepdly=3, swmsk=0 -> orst_ rises at edge 16; rstmsk[0] clears at edge 20; rstmsk[i] clears at edge 16+4(i+1); rstmsk[21] clears, done=1 and busy=0 at edge 104.
REQ-030 The bench SHALL cover: stepdly=0, swmsk=22'h000005 -> bits 0 and 2 stay 1; bit 1 clears at edge 18; done at edge 38; then clearing swmsk[2] in DONE clears rstmsk[2] on the next edge.
REQ-031 The bench SHALL cover: swrst pulsed for 1 cycle at edge 50 of scenario REQ-029 -> on that edge orst_=0, rstmsk=3FFFFF, busy=1; orst_ rises again 16 edges after swrst falls.
REQ-032 The bench SHALL cover: stepdly changed from 3 to 9 during STAGE -> release spacing stays 4 cycles until done.
REQ-033 The bench SHALL cover: rst_ asserted asynchronously, between clock edges, in DONE -> orst_=0, rstmsk=3FFFFF and done=0 before the next clk edge.
REQ-034 The bench SHALL cover: swrst held high for 10 cycles from rst_ release -> orst_ remains 0 throughout; orst_ rises 16 edges after swrst falls.
